// File: rtl/artau_pkg.sv
// -----------------------------------------------------------------------------
// artau_pkg
// Shared types and constants for the Airborne Radar Target Acquisition Unit.
//   - artau_state_e : FSM state encoding (also driven out on ARTAU_state)
//   - *_DEF         : default timing constants used as top-level parameter defaults
//   - US_PER_S      : microseconds per second, used by the closing-speed test
//   - sat32()       : clamp a 64-bit product into 32 bits
// Optional feature macro used by this slice: ARTAU_RETRIGGER_EN (see top).
// -----------------------------------------------------------------------------
package artau_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EMIT   = 2'b01,
    LISTEN = 2'b10,
    ASSESS = 2'b11
  } artau_state_e;

  localparam int unsigned CLK_PERIOD_US_DEF = 100;
  localparam int unsigned PULSE_CYCLES_DEF  = 3;
  localparam int unsigned LISTEN_CYCLES_DEF = 20;
  localparam int unsigned ASSESS_CYCLES_DEF = 30;
  localparam int unsigned M_PER_US_DEF      = 150;

  localparam logic [63:0] US_PER_S = 64'd1_000_000;

  function automatic logic [31:0] sat32(input logic [63:0] v);
    return (|v[63:32]) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

endpackage

// File: rtl/artau_echo_latch.sv
// -----------------------------------------------------------------------------
// artau_echo_latch
// Sticky flag that catches echo pulses shorter than a clock period.
//   clk_i     : system clock
//   rst_i     : asynchronous active-high reset
//   echo_i    : raw echo, asynchronous to clk_i; its rising edge sets the flag
//   clr_i     : synchronous clear, applied on the clk_i edge
//   pending_o : flag output
// While echo_i is still high at a clock edge the set dominates the clear, so
// an echo overlapping the clear edge is never lost.
// -----------------------------------------------------------------------------
module artau_echo_latch (
  input  logic clk_i,
  input  logic rst_i,
  input  logic echo_i,
  input  logic clr_i,
  output logic pending_o
);

  logic pending_q;

  always_ff @(posedge clk_i or posedge rst_i or posedge echo_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
    end else if (echo_i) begin
      pending_q <= 1'b1;
    end else if (clr_i) begin
      pending_q <= 1'b0;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/artau_radar_unit.sv
// -----------------------------------------------------------------------------
// artau_radar_unit
// Emits two radar pulses per scan, times both echoes into ranges, then decides
// whether the target is inside the safe distance and closing faster than own
// speed. The FSM state is exported on ARTAU_state for observation.
//   CLK                 : system clock
//   RST                 : asynchronous active-high reset
//   radar_echo          : echo pulse (may be very short, asynchronous)
//   scan_for_target     : scan request level, sampled on CLK (no handshake; it
//                         is only acted on in IDLE, or in ASSESS when retrigger
//                         is built in)
//   jet_speed           : own speed, m/s
//   max_safe_distance   : threat range limit, metres
//   radar_pulse_trigger : high while emitting
//   distance_to_target  : last measured range, metres
//   threat_detected     : assessment result
//   ARTAU_state         : current FSM state
// Build option: define ARTAU_RETRIGGER_EN to let a scan in ASSESS restart.
// -----------------------------------------------------------------------------
module artau_radar_unit
  import artau_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_US = CLK_PERIOD_US_DEF,
  parameter int unsigned PULSE_CYCLES  = PULSE_CYCLES_DEF,
  parameter int unsigned LISTEN_CYCLES = LISTEN_CYCLES_DEF,
  parameter int unsigned ASSESS_CYCLES = ASSESS_CYCLES_DEF,
  parameter int unsigned M_PER_US      = M_PER_US_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_echo,
  input  logic        scan_for_target,
  input  logic [31:0] jet_speed,
  input  logic [31:0] max_safe_distance,
  output logic        radar_pulse_trigger,
  output logic [31:0] distance_to_target,
  output logic        threat_detected,
  output logic [1:0]  ARTAU_state
);

  artau_state_e state_q;
  logic         idx_q;      // 0: first pulse, 1: second pulse
  logic [31:0]  pc_q;       // cycles spent emitting
  logic [31:0]  lc_q;       // cycles spent listening
  logic [31:0]  ac_q;       // cycles spent in ASSESS
  logic [31:0]  dt_q;       // cycles between the two echo captures
  logic         dt_run_q;
  logic [31:0]  d1_q;
  logic         trig_q;
  logic [31:0]  dist_q;
  logic         threat_q;

  logic         echo_pending;
  logic         echo_clr;

  // Outside LISTEN the flag is always flushed; inside LISTEN a set flag is
  // consumed on the same edge, so clearing it then is the capture.
  assign echo_clr = (state_q != LISTEN) || echo_pending;

  artau_echo_latch u_echo_latch (
    .clk_i     (CLK),
    .rst_i     (RST),
    .echo_i    (radar_echo),
    .clr_i     (echo_clr),
    .pending_o (echo_pending)
  );

  logic [31:0] elapsed;
  logic [31:0] range_m;
  logic [31:0] dt_next;
  logic [63:0] dt_us;
  logic [63:0] closing_lhs;
  logic [63:0] closing_rhs;
  logic        threat_eval;

  always_comb begin
    elapsed     = lc_q + 32'd1;
    range_m     = sat32(64'(elapsed) * 64'(CLK_PERIOD_US) * 64'(M_PER_US));
    // The second capture edge itself counts toward the inter-echo time.
    dt_next     = dt_q + 32'd1;
    dt_us       = 64'(dt_next) * 64'(CLK_PERIOD_US);
    closing_lhs = (64'(d1_q) - 64'(range_m)) * US_PER_S;
    closing_rhs = 64'(jet_speed) * dt_us;
    threat_eval = (range_m < max_safe_distance) && (range_m < d1_q) &&
                  (closing_lhs > closing_rhs);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      idx_q    <= 1'b0;
      pc_q     <= '0;
      lc_q     <= '0;
      ac_q     <= '0;
      dt_q     <= '0;
      dt_run_q <= 1'b0;
      d1_q     <= '0;
      trig_q   <= 1'b0;
      dist_q   <= '0;
      threat_q <= 1'b0;
    end else begin
      if (dt_run_q) dt_q <= dt_next;
      case (state_q)
        IDLE: begin
          if (scan_for_target) begin
            state_q <= EMIT;
            idx_q   <= 1'b0;
            pc_q    <= '0;
            trig_q  <= 1'b1;
          end
        end
        EMIT: begin
          if (pc_q == 32'(PULSE_CYCLES - 1)) begin
            state_q <= LISTEN;
            trig_q  <= 1'b0;
            lc_q    <= '0;
          end else begin
            pc_q <= pc_q + 32'd1;
          end
        end
        LISTEN: begin
          if (echo_pending) begin
            dist_q <= range_m;
            if (!idx_q) begin
              d1_q     <= range_m;
              dt_q     <= '0;
              dt_run_q <= 1'b1;
              idx_q    <= 1'b1;
              pc_q     <= '0;
              trig_q   <= 1'b1;
              state_q  <= EMIT;
            end else begin
              dt_run_q <= 1'b0;
              threat_q <= threat_eval;
              ac_q     <= '0;
              state_q  <= ASSESS;
            end
          end else if (elapsed == 32'(LISTEN_CYCLES)) begin
            state_q  <= IDLE;
            dist_q   <= '0;
            threat_q <= 1'b0;
            dt_run_q <= 1'b0;
          end else begin
            lc_q <= elapsed;
          end
        end
        ASSESS: begin
`ifdef ARTAU_RETRIGGER_EN
          // Distance and threat stay as they are until overwritten.
          if (scan_for_target) begin
            state_q <= EMIT;
            idx_q   <= 1'b0;
            pc_q    <= '0;
            trig_q  <= 1'b1;
          end else
`endif
          if (ac_q == 32'(ASSESS_CYCLES - 1)) begin
            state_q  <= IDLE;
            dist_q   <= '0;
            threat_q <= 1'b0;
          end else begin
            ac_q <= ac_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign radar_pulse_trigger = trig_q;
  assign distance_to_target  = dist_q;
  assign threat_detected     = threat_q;
  assign ARTAU_state         = state_q;

endmodule

// File: tb/tb_artau_radar_unit.sv
// -----------------------------------------------------------------------------
// tb_artau_radar_unit
// Directed plus randomized scans of artau_radar_unit. Expected ranges, inter-
// echo times and threat decisions are computed from the unit's rules with
// plain arithmetic. Inputs change 1 ns after a rising edge; outputs are
// sampled there too.
// -----------------------------------------------------------------------------
module tb_artau_radar_unit;

  localparam longint unsigned T_US   = 100;
  localparam longint unsigned M_US   = 150;
  localparam int              PULSE  = 3;
  localparam int              LISTEN = 20;
  localparam int              HOLD   = 30;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_EMIT   = 2'b01;
  localparam logic [1:0] S_LISTEN = 2'b10;
  localparam logic [1:0] S_ASSESS = 2'b11;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        radar_echo = 1'b0;
  logic        scan_for_target = 1'b0;
  logic [31:0] jet_speed = '0;
  logic [31:0] max_safe_distance = '0;
  logic        radar_pulse_trigger;
  logic [31:0] distance_to_target;
  logic        threat_detected;
  logic [1:0]  ARTAU_state;

  int checks = 0;
  int errors = 0;

  artau_radar_unit dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .radar_echo          (radar_echo),
    .scan_for_target     (scan_for_target),
    .jet_speed           (jet_speed),
    .max_safe_distance   (max_safe_distance),
    .radar_pulse_trigger (radar_pulse_trigger),
    .distance_to_target  (distance_to_target),
    .threat_detected     (threat_detected),
    .ARTAU_state         (ARTAU_state)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic longint unsigned model_range(input int k);
    return longint'(k) * T_US * M_US;
  endfunction

  // k1/k2: LISTEN cycle (1-based) in which each echo arrives.
  function automatic bit model_threat(input int k1, input int k2,
                                      input longint unsigned spd,
                                      input longint unsigned maxd);
    longint unsigned d1, d2, dt_us;
    d1    = model_range(k1);
    d2    = model_range(k2);
    dt_us = longint'(PULSE + k2) * T_US;
    return (d2 < maxd) && (d2 < d1) && ((d1 - d2) * 64'd1_000_000 > spd * dt_us);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_echo();
    radar_echo = 1'b1;
    #1;
    radar_echo = 1'b0;
  endtask

  task automatic start_scan();
    scan_for_target = 1'b1;
    tick();
    scan_for_target = 1'b0;
    check("emit_state", 64'(ARTAU_state), 64'(S_EMIT));
    check("emit_trig", 64'(radar_pulse_trigger), 64'd1);
    tick();
    tick();
    check("emit_last_trig", 64'(radar_pulse_trigger), 64'd1);
    tick();
    check("listen_state", 64'(ARTAU_state), 64'(S_LISTEN));
    check("listen_trig", 64'(radar_pulse_trigger), 64'd0);
  endtask

  task automatic echo_in_cycle(input int k);
    repeat (k - 1) tick();
    pulse_echo();
    tick();
  endtask

  // First echo in LISTEN cycle k1; then the second in k2, or a timeout if k2==0.
  task automatic run_scan(input int k1, input int k2, input bit finish_hold);
    bit exp_threat;
    start_scan();
    echo_in_cycle(k1);
    check("d1", 64'(distance_to_target), model_range(k1));
    check("reemit_state", 64'(ARTAU_state), 64'(S_EMIT));
    check("reemit_trig", 64'(radar_pulse_trigger), 64'd1);
    repeat (PULSE) tick();
    check("listen2_state", 64'(ARTAU_state), 64'(S_LISTEN));
    if (k2 == 0) begin
      repeat (LISTEN - 1) tick();
      check("timeout_pre", 64'(ARTAU_state), 64'(S_LISTEN));
      check("timeout_pre_dist", 64'(distance_to_target), model_range(k1));
      tick();
      check("timeout_state", 64'(ARTAU_state), 64'(S_IDLE));
      check("timeout_dist", 64'(distance_to_target), 64'd0);
      check("timeout_threat", 64'(threat_detected), 64'd0);
    end else begin
      echo_in_cycle(k2);
      exp_threat = model_threat(k1, k2, 64'(jet_speed), 64'(max_safe_distance));
      check("assess_state", 64'(ARTAU_state), 64'(S_ASSESS));
      check("d2", 64'(distance_to_target), model_range(k2));
      check("threat", 64'(threat_detected), 64'(exp_threat));
      if (finish_hold) begin
        repeat (HOLD - 1) tick();
        check("hold_state", 64'(ARTAU_state), 64'(S_ASSESS));
        check("hold_dist", 64'(distance_to_target), model_range(k2));
        check("hold_threat", 64'(threat_detected), 64'(exp_threat));
        tick();
        check("end_state", 64'(ARTAU_state), 64'(S_IDLE));
        check("end_dist", 64'(distance_to_target), 64'd0);
        check("end_threat", 64'(threat_detected), 64'd0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(ARTAU_state), 64'(S_IDLE));
    check({tag, "_trig"}, 64'(radar_pulse_trigger), 64'd0);
    check({tag, "_dist"}, 64'(distance_to_target), 64'd0);
    check({tag, "_threat"}, 64'(threat_detected), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k1, k2;

    // Reset, then idle with no scan.
    repeat (3) tick();
    RST = 1'b0;
    repeat (5) tick();
    check_reset_outputs("reset");

    // Equal ranges: not closing.
    max_safe_distance = 32'd20000;
    jet_speed         = 32'd7000;
    run_scan(1, 1, 1'b1);

    // Closing inside the limit.
    run_scan(2, 1, 1'b1);

    // Closing but outside the limit.
    max_safe_distance = 32'd10000;
    run_scan(2, 1, 1'b1);

    // Second echo never arrives.
    run_scan(3, 0, 1'b0);

    // Latest possible echoes in both windows.
    max_safe_distance = 32'hFFFF_FFFF;
    jet_speed         = 32'd0;
    run_scan(LISTEN, LISTEN - 1, 1'b1);

    // Scan during ASSESS.
    max_safe_distance = 32'd20000;
    jet_speed         = 32'd7000;
    run_scan(2, 1, 1'b0);
    tick();
    scan_for_target = 1'b1;
    tick();
    scan_for_target = 1'b0;
`ifdef ARTAU_RETRIGGER_EN
    check("retrig_state", 64'(ARTAU_state), 64'(S_EMIT));
    check("retrig_trig", 64'(radar_pulse_trigger), 64'd1);
    check("retrig_dist_held", 64'(distance_to_target), model_range(1));
    check("retrig_threat_held", 64'(threat_detected), 64'(model_threat(2, 1, 64'd7000, 64'd20000)));
`else
    check("noretrig_state", 64'(ARTAU_state), 64'(S_ASSESS));
    check("noretrig_trig", 64'(radar_pulse_trigger), 64'd0);
    check("noretrig_dist", 64'(distance_to_target), model_range(1));
`endif
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_assess");
    tick();
    RST = 1'b0;
    tick();

    // Reset in the middle of the second LISTEN window.
    start_scan();
    echo_in_cycle(4);
    repeat (PULSE + 2) tick();
    check("mid_listen", 64'(ARTAU_state), 64'(S_LISTEN));
    RST = 1'b1;
    #1;
    check_reset_outputs("rst_listen");
    tick();
    RST = 1'b0;
    repeat (2) tick();
    check_reset_outputs("post_rst");

    // Randomized scans.
    for (int n = 0; n < 10; n++) begin
      k1 = $urandom_range(1, LISTEN);
      k2 = $urandom_range(1, LISTEN);
      max_safe_distance = $urandom_range(0, 320000);
      jet_speed         = $urandom_range(0, 300_000_000);
      run_scan(k1, k2, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/artau_radar_unit.md
Name: artau_radar_unit

Overview:
- Airborne Radar Target Acquisition Unit for the jet's sensor subsystem.
- On a scan request it emits two radar pulses and times each echo to compute range.
- It then assesses whether the target is a threat from both ranges, the time between echoes, own-jet speed and the safe-distance limit.
- Result goes to the fire-control/warning logic.

Parameters:
- CLK_PERIOD_US, 100, clock period in microseconds; sets timing resolution.
- PULSE_CYCLES, 3, radar pulse length in cycles (300 us).
- LISTEN_CYCLES, 20, echo wait window in cycles (2000 us).
- ASSESS_CYCLES, 30, assessment hold time in cycles (3000 us).
- M_PER_US, 150, metres of range per microsecond of round trip (c/2).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-high reset
- radar_echo  in  1  echo pulse; may be far shorter than a clock period and asynchronous to CLK
- scan_for_target  in  1  scan request, sampled on CLK
- jet_speed  in  32  own speed, m/s, unsigned
- max_safe_distance  in  32  threat range limit, metres, unsigned
- radar_pulse_trigger  out  1  high while emitting
- distance_to_target  out  32  last measured range, metres
- threat_detected  out  1  assessment result
- ARTAU_state  out  2  current state

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (CLK, RST).
- States: IDLE=00, EMIT=01, LISTEN=10, ASSESS=11. All outputs are registered.
- Reset state: IDLE. All outputs 0. All counters, the pulse index and the echo latch are cleared.
- Echo capture: echo_pending is set asynchronously by the rising edge of radar_echo. It is cleared synchronously on every CLK edge where the state is not LISTEN, and on the capture edge. If set and clear coincide, set wins.
- IDLE:
  - On scan_for_target=1: go to EMIT, pulse index=0, radar_pulse_trigger=1.
- EMIT:
  - Trigger stays high for exactly PULSE_CYCLES cycles.
  - Then go to LISTEN with trigger=0 and listen counter lc=0.
  - If the pulse index is 1, the inter-echo counter keeps counting.
- LISTEN, on each edge:
  - If echo_pending: elapsed=lc+1; distance_to_target = elapsed*CLK_PERIOD_US*M_PER_US. This uses a 32-bit result and saturates at 0xFFFFFFFF.
  - First echo (index 0): store d1; start the inter-echo counter dt=0; go to EMIT with index=1.
  - Second echo (index 1): store d2; go to ASSESS.
  - If no echo and lc+1==LISTEN_CYCLES: go to IDLE; distance_to_target=0 and threat_detected=0.
  - Otherwise lc increments.
- Inter-echo counter dt:
  - Increments every edge from the first capture edge (exclusive) to the second capture edge (inclusive).
  - dt_us = dt*CLK_PERIOD_US.
- Threat evaluation, on entry to ASSESS, registered at the same edge:
  - threat_detected = (d2 < max_safe_distance) AND (d2 < d1) AND ((d1−d2)*1_000_000 > jet_speed*dt_us).
  - Use 64-bit products.
  - In words: the target is inside the limit and closing faster than own speed.
- ASSESS:
  - Holds distance and threat for ASSESS_CYCLES cycles, then goes to IDLE and clears distance and threat to 0.
  - Retrigger on scan_for_target is controlled by the optional feature below.
- RST mid-operation returns the block to the reset state immediately.

Optional Feature:
- Macro: ARTAU_RETRIGGER_EN.
- Defined:
  - scan_for_target=1 in ASSESS goes to EMIT with index=0 and trigger=1.
  - Previous distance and threat are held until the next capture or evaluation.
- Undefined:
  - scan_for_target is ignored in ASSESS; only IDLE accepts a scan.

Decomposition:
- Package artau_pkg: state enum (IDLE/EMIT/LISTEN/ASSESS encodings), default timing constants, and the US_PER_S=1_000_000 constant.
- One sub-module, artau_echo_latch: asynchronous-set, synchronous-clear sticky flag for short echo pulses.
- The FSM, counters and arithmetic live in the top module.

Test Plan:
1. Reset release, no scan for 5 cycles -> state 00; trigger, distance and threat all 0.
2. Scan pulse sampled at edge T -> state 01 and trigger=1 from T for 3 cycles; state 10 at T+3.
   - Then 2 us echo in the 1st LISTEN cycle -> distance=15000.
   - Re-emit 3 cycles; echo in the 1st LISTEN cycle -> distance=15000; ASSESS with threat=0 (d2==d1).
   - After 30 cycles -> IDLE; distance=0.
3. max_safe_distance=20000, jet_speed=7000.
   - First echo in LISTEN cycle 2 -> d1=30000.
   - Second echo in cycle 1 -> d2=15000, dt=4 cycles (400 us).
   - Result: threat=1.
4. Same as 3 but max_safe_distance=10000 -> threat=0.
5. Scan, then no echo for 20 LISTEN cycles -> IDLE; distance=0.
6. Scan during ASSESS:
   - With ARTAU_RETRIGGER_EN -> EMIT next edge.
   - Without it -> stays in ASSESS.
   - RST pulse mid-LISTEN -> immediate 00 with all outputs 0.
